// File: rtl/frame_serializer.sv
// Parallel-to-serial frame unloader: captures a LENGTH-word frame and streams it
// one word per accepted beat with binary index, one-hot slot and last flag.
module frame_serializer #(
    parameter  int LENGTH = 4,
    parameter  int WIDTH  = 16,
    localparam int IDX_W  = $clog2(LENGTH)
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LENGTH*WIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [IDX_W-1:0]        m_index,
    output logic                    m_last,
    output logic [LENGTH-1:0]       slot,
    output logic                    busy
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LENGTH - 1);
    localparam logic [LENGTH-1:0] SLOT_FIRST = LENGTH'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_index;
    logic [IDX_W-1:0]   w_next_index;
    logic [LENGTH-1:0]  r_slot;
    logic [LENGTH-1:0]  w_next_slot;
    logic [WIDTH-1:0]   r_buf [LENGTH];

    logic w_send;
    logic w_last;
    logic w_beat;
    logic w_load;

    assign w_send = (r_state == ST_SEND);
    assign w_last = w_send && (r_index == LAST_IDX);
    assign w_beat = w_send && enable && m_ready;

    // A new frame may enter while idle, or on the very edge the last word leaves.
    assign s_ready = !arst && (!w_send || (w_beat && w_last));
    assign w_load  = s_valid && s_ready;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_next_slot  = r_slot;
        if (w_load) begin
            w_next_state = ST_SEND;
            w_next_index = '0;
            w_next_slot  = SLOT_FIRST;
        end else if (w_beat) begin
            if (w_last) begin
                w_next_state = ST_IDLE;
                w_next_index = '0;
                w_next_slot  = '0;
            end else begin
                w_next_index = r_index + IDX_W'(1);
                w_next_slot  = {r_slot[LENGTH-2:0], r_slot[LENGTH-1]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_slot  <= '0;
        end else begin
            r_state <= w_next_state;
            r_index <= w_next_index;
            r_slot  <= w_next_slot;
        end
    end

    // NOTE: the frame buffer is reset on purpose so a dropped frame never leaks onto m_data.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < LENGTH; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_load) begin
            for (int k = 0; k < LENGTH; k++) begin
                r_buf[k] <= s_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign m_valid = w_send && enable;
    assign m_data  = r_buf[r_index];
    assign m_index = r_index;
    assign m_last  = w_last;
    assign slot    = r_slot;
    assign busy    = w_send;

    // The slot vector must track the index exactly while sending and be at most one-hot.
    slot_onehot0_a : assert property (@(posedge clk) disable iff (arst) $onehot0(r_slot));
    slot_tracks_idx_a : assert property (@(posedge clk) disable iff (arst)
        w_send |-> (r_slot == (SLOT_FIRST << r_index)));

endmodule

// File: tb/tb_frame_serializer.sv
// Directed self-checking bench for frame_serializer (LENGTH=4, WIDTH=16).
module tb_frame_serializer;

    localparam int LENGTH = 4;
    localparam int WIDTH  = 16;

    logic                    clk;
    logic                    arst;
    logic                    enable;
    logic                    s_valid;
    logic                    s_ready;
    logic [LENGTH*WIDTH-1:0] s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [WIDTH-1:0]        m_data;
    logic [1:0]              m_index;
    logic                    m_last;
    logic [LENGTH-1:0]       slot;
    logic                    busy;

    int n_vec;
    int n_err;

    frame_serializer #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .arst    (arst),
        .enable  (enable),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_index (m_index),
        .m_last  (m_last),
        .slot    (slot),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame whose word k equals base + k.
    function automatic logic [LENGTH*WIDTH-1:0] pack(input logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    // Checks one streaming beat; assumes enable=1 and m_ready=1.
    task automatic expect_word(input string tag, input logic [15:0] data, input int idx);
        #1;
        check({tag, ".m_valid"}, 64'(m_valid), 64'd1);
        check({tag, ".m_data"},  64'(m_data),  64'(data));
        check({tag, ".m_index"}, 64'(m_index), 64'(idx));
        check({tag, ".m_last"},  64'(m_last),  64'(idx == 3));
        check({tag, ".slot"},    64'(slot),    64'(4'b0001 << idx));
        check({tag, ".busy"},    64'(busy),    64'd1);
        check({tag, ".s_ready"}, 64'(s_ready), 64'(idx == 3));
    endtask

    task automatic expect_idle(input string tag);
        #1;
        check({tag, ".m_valid"}, 64'(m_valid), 64'd0);
        check({tag, ".m_last"},  64'(m_last),  64'd0);
        check({tag, ".slot"},    64'(slot),    64'd0);
        check({tag, ".busy"},    64'(busy),    64'd0);
        check({tag, ".s_ready"}, 64'(s_ready), 64'd1);
    endtask

    // Capture a frame and stream it fully at full throughput.
    task automatic run_frame(input string tag, input logic [15:0] base);
        s_data  = pack(base);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < LENGTH; k++) begin
            expect_word(tag, base + 16'(k), k);
            tick();
        end
        expect_idle({tag, ".end"});
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        arst    = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;

        // Reset state
        #2;
        check("rst.s_ready", 64'(s_ready), 64'd0);
        check("rst.m_valid", 64'(m_valid), 64'd0);
        check("rst.m_data",  64'(m_data),  64'd0);
        check("rst.m_last",  64'(m_last),  64'd0);
        check("rst.m_index", 64'(m_index), 64'd0);
        check("rst.slot",    64'(slot),    64'd0);
        check("rst.busy",    64'(busy),    64'd0);
        tick();
        tick();
        arst    = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        expect_idle("rel");

        // Single frame 1,2,3,4
        run_frame("f1", 16'h0001);

        // Back-to-back frames A then B with s_valid held throughout
        s_data  = pack(16'hA000);
        s_valid = 1'b1;
        tick();
        s_data = pack(16'hB000);
        for (int k = 0; k < LENGTH; k++) begin
            expect_word("b2b.A", 16'hA000 + 16'(k), k);
            tick();
        end
        s_valid = 1'b0;
        for (int k = 0; k < LENGTH; k++) begin
            expect_word("b2b.B", 16'hB000 + 16'(k), k);
            tick();
        end
        expect_idle("b2b.end");

        // Backpressure at index 1 for 3 cycles
        s_data  = pack(16'hC000);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        expect_word("bp.0", 16'hC000, 0);
        tick();
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.hold.m_valid", 64'(m_valid), 64'd1);
            check("bp.hold.m_data",  64'(m_data),  64'hC001);
            check("bp.hold.m_index", 64'(m_index), 64'd1);
            check("bp.hold.slot",    64'(slot),    64'b0010);
            check("bp.hold.s_ready", 64'(s_ready), 64'd0);
            tick();
        end
        m_ready = 1'b1;
        expect_word("bp.1", 16'hC001, 1);
        tick();
        expect_word("bp.2", 16'hC002, 2);
        tick();
        expect_word("bp.3", 16'hC003, 3);
        tick();
        expect_idle("bp.end");

        // enable low for 2 cycles at index 1
        s_data  = pack(16'hD000);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        expect_word("en.0", 16'hD000, 0);
        tick();
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("en.off.m_valid", 64'(m_valid), 64'd0);
            check("en.off.m_index", 64'(m_index), 64'd1);
            check("en.off.m_data",  64'(m_data),  64'hD001);
            check("en.off.busy",    64'(busy),    64'd1);
            check("en.off.s_ready", 64'(s_ready), 64'd0);
            tick();
        end
        enable = 1'b1;
        for (int k = 1; k < LENGTH; k++) begin
            expect_word("en.on", 16'hD000 + 16'(k), k);
            tick();
        end
        expect_idle("en.end");

        // Asynchronous reset mid-frame at index 2
        s_data  = pack(16'hE000);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        expect_word("ar.pre", 16'hE002, 2);
        #2;
        arst = 1'b1;
        #1;
        check("ar.s_ready", 64'(s_ready), 64'd0);
        check("ar.m_valid", 64'(m_valid), 64'd0);
        check("ar.m_data",  64'(m_data),  64'd0);
        check("ar.m_index", 64'(m_index), 64'd0);
        check("ar.m_last",  64'(m_last),  64'd0);
        check("ar.slot",    64'(slot),    64'd0);
        check("ar.busy",    64'(busy),    64'd0);
        tick();
        arst = 1'b0;
        expect_idle("ar.rel");
        run_frame("ar.next", 16'hF000);

        // Capture with enable low, then change s_data after capture
        enable  = 1'b0;
        s_data  = pack(16'h1230);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_data  = {LENGTH{16'hDEAD}};
        #1;
        check("cap.en0.m_valid", 64'(m_valid), 64'd0);
        check("cap.en0.busy",    64'(busy),    64'd1);
        check("cap.en0.m_index", 64'(m_index), 64'd0);
        tick();
        enable = 1'b1;
        for (int k = 0; k < LENGTH; k++) begin
            expect_word("cap", 16'h1230 + 16'(k), k);
            tick();
        end
        expect_idle("cap.end");

        // s_valid raised mid-frame is held off until the last beat
        s_data  = pack(16'h4000);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        expect_word("ill.0", 16'h4000, 0);
        tick();
        s_data  = pack(16'h5000);
        s_valid = 1'b1;
        for (int k = 1; k < LENGTH; k++) begin
            expect_word("ill.H", 16'h4000 + 16'(k), k);
            tick();
        end
        s_valid = 1'b0;
        for (int k = 0; k < LENGTH; k++) begin
            expect_word("ill.I", 16'h5000 + 16'(k), k);
            tick();
        end
        expect_idle("ill.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
